// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM generator: channel alignment
// mode encodings and the default counter width.
package pwm_pkg;

   localparam logic [1:0] PWM_LEFT      = 2'b00;
   localparam logic [1:0] PWM_RIGHT     = 2'b01;
   localparam logic [1:0] PWM_UNALIGNED = 2'b10;
   localparam logic [1:0] PWM_OFF       = 2'b11;

   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: active configuration registers reloaded on apply cycles,
// compare logic against the shared counter, and the registered output.
module pwm_chan
   import pwm_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_en,
   input  logic             apply,
   input  logic [CNT_W-1:0] count_val,
   input  logic [1:0]       mode_nxt,
   input  logic             pol_nxt,
   input  logic [CNT_W-1:0] c1_nxt,
   input  logic [CNT_W-1:0] c2_nxt,
   output logic             pwm_out
);

   logic [1:0]       mode_r;
   logic             pol_r;
   logic [CNT_W-1:0] c1_r;
   logic [CNT_W-1:0] c2_r;
   logic             raw_s;
   logic             pwm_out_r;

   // Active config: only changes on period boundaries or while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r <= PWM_LEFT;
         pol_r  <= 1'b0;
         c1_r   <= {CNT_W{1'b0}};
         c2_r   <= {CNT_W{1'b0}};
      end else if (apply) begin
         mode_r <= mode_nxt;
         pol_r  <= pol_nxt;
         c1_r   <= c1_nxt;
         c2_r   <= c2_nxt;
      end
   end

   // Raw active level; unaligned with c2 <= c1 can never satisfy both bounds
   always_comb begin
      raw_s = 1'b0;
      case (mode_r)
         PWM_LEFT:      raw_s = (count_val < c1_r);
         PWM_RIGHT:     raw_s = (count_val >= c1_r);
         PWM_UNALIGNED: raw_s = (count_val >= c1_r) && (count_val < c2_r);
         PWM_OFF:       raw_s = 1'b0;
         default:       raw_s = 1'b0;
      endcase
   end

   // Output flop with polarity; disabled forces low regardless of polarity
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_out_r <= 1'b0;
      end else begin
         pwm_out_r <= pwm_en ? (raw_s ^ pol_r) : 1'b0;
      end
   end

   assign pwm_out = pwm_out_r;

endmodule

// File: rtl/pwm_gen_mc.sv
// Multi-channel PWM generator: shared period counter, double-buffered
// configuration (staging -> active at period boundary) and CH channels.
module pwm_gen_mc
   import pwm_pkg::*;
#(
   parameter int CH    = 4,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pwm_en,
   input  logic                cfg_wr,
   input  logic [CNT_W-1:0]    period,
   input  logic [2*CH-1:0]     mode,
   input  logic [CH-1:0]       pol,
   input  logic [CH*CNT_W-1:0] compare1,
   input  logic [CH*CNT_W-1:0] compare2,
   output logic [CH-1:0]       pwm_out,
   output logic [CNT_W-1:0]    count_val,
   output logic                period_evt,
   output logic                cfg_pending
);

   logic [CNT_W-1:0]    count_r;
   logic [CNT_W-1:0]    period_act_r;
   logic [CNT_W-1:0]    period_stg_r;
   logic [2*CH-1:0]     mode_stg_r;
   logic [CH-1:0]       pol_stg_r;
   logic [CH*CNT_W-1:0] c1_stg_r;
   logic [CH*CNT_W-1:0] c2_stg_r;
   logic                pending_r;

   logic [CNT_W-1:0]    period_nxt_s;
   logic [2*CH-1:0]     mode_nxt_s;
   logic [CH-1:0]       pol_nxt_s;
   logic [CH*CNT_W-1:0] c1_nxt_s;
   logic [CH*CNT_W-1:0] c2_nxt_s;
   logic                wrap_s;
   logic                apply_s;

   assign wrap_s  = pwm_en && (count_r == period_act_r);
   assign apply_s = wrap_s || !pwm_en;

   // A write landing on an apply cycle bypasses staging straight into active
   always_comb begin
      if (cfg_wr) begin
         period_nxt_s = period;
         mode_nxt_s   = mode;
         pol_nxt_s    = pol;
         c1_nxt_s     = compare1;
         c2_nxt_s     = compare2;
      end else begin
         period_nxt_s = period_stg_r;
         mode_nxt_s   = mode_stg_r;
         pol_nxt_s    = pol_stg_r;
         c1_nxt_s     = c1_stg_r;
         c2_nxt_s     = c2_stg_r;
      end
   end

   // Staging registers, rewritten on every cycle the strobe is high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_stg_r <= {CNT_W{1'b0}};
         mode_stg_r   <= {(2*CH){1'b0}};
         pol_stg_r    <= {CH{1'b0}};
         c1_stg_r     <= {(CH*CNT_W){1'b0}};
         c2_stg_r     <= {(CH*CNT_W){1'b0}};
      end else if (cfg_wr) begin
         period_stg_r <= period;
         mode_stg_r   <= mode;
         pol_stg_r    <= pol;
         c1_stg_r     <= compare1;
         c2_stg_r     <= compare2;
      end
   end

   // Counter, active period and pending flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r      <= {CNT_W{1'b0}};
         period_act_r <= {CNT_W{1'b0}};
         pending_r    <= 1'b0;
      end else begin
         if (apply_s) begin
            count_r <= {CNT_W{1'b0}};
         end else begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (apply_s) begin
            period_act_r <= period_nxt_s;
            pending_r    <= 1'b0;
         end else if (cfg_wr) begin
            pending_r    <= 1'b1;
         end
      end
   end

   for (genvar i = 0; i < CH; i++) begin : g_chan
      pwm_chan #(
         .CNT_W (CNT_W)
      ) u_chan (
         .clk       (clk),
         .rst_n     (rst_n),
         .pwm_en    (pwm_en),
         .apply     (apply_s),
         .count_val (count_r),
         .mode_nxt  (mode_nxt_s[2*i +: 2]),
         .pol_nxt   (pol_nxt_s[i]),
         .c1_nxt    (c1_nxt_s[i*CNT_W +: CNT_W]),
         .c2_nxt    (c2_nxt_s[i*CNT_W +: CNT_W]),
         .pwm_out   (pwm_out[i])
      );
   end

   assign count_val   = count_r;
   assign period_evt  = wrap_s;
   assign cfg_pending = pending_r;

endmodule

// File: tb/tb_pwm_gen_mc.sv
// Bench for pwm_gen_mc: a cycle model feeds a scoreboard queue checked every
// cycle, and scenario tasks check pulse widths and timing directly.
module tb_pwm_gen_mc;

   localparam int CH    = 4;
   localparam int CNT_W = 16;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                pwm_en = 1'b0;
   logic                cfg_wr = 1'b0;
   logic [CNT_W-1:0]    period = '0;
   logic [2*CH-1:0]     mode = '0;
   logic [CH-1:0]       pol = '0;
   logic [CH*CNT_W-1:0] compare1 = '0;
   logic [CH*CNT_W-1:0] compare2 = '0;
   logic [CH-1:0]       pwm_out;
   logic [CNT_W-1:0]    count_val;
   logic                period_evt;
   logic                cfg_pending;

   int checks = 0;
   int errors = 0;

   pwm_gen_mc #(.CH(CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .pwm_en(pwm_en), .cfg_wr(cfg_wr),
      .period(period), .mode(mode), .pol(pol),
      .compare1(compare1), .compare2(compare2),
      .pwm_out(pwm_out), .count_val(count_val),
      .period_evt(period_evt), .cfg_pending(cfg_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CH-1:0]    out;
      logic [CNT_W-1:0] cnt;
      logic             pend;
   } exp_t;

   exp_t sb_q[$];

   logic [CNT_W-1:0] m_cnt, m_per, s_per;
   logic [1:0]       m_mode [CH];
   logic [1:0]       s_mode [CH];
   logic             m_pol  [CH];
   logic             s_pol  [CH];
   logic [CNT_W-1:0] m_c1   [CH];
   logic [CNT_W-1:0] s_c1   [CH];
   logic [CNT_W-1:0] m_c2   [CH];
   logic [CNT_W-1:0] s_c2   [CH];
   logic             m_pend;

   task automatic model_reset();
      m_cnt = '0; m_per = '0; s_per = '0; m_pend = 1'b0;
      for (int i = 0; i < CH; i++) begin
         m_mode[i] = 2'b00; s_mode[i] = 2'b00;
         m_pol[i]  = 1'b0;  s_pol[i]  = 1'b0;
         m_c1[i]   = '0;    s_c1[i]   = '0;
         m_c2[i]   = '0;    s_c2[i]   = '0;
      end
   endtask

   // Reference model: predicts post-edge state, scoreboard compares 1 time unit later
   initial begin : monitor
      exp_t             e;
      exp_t             got;
      logic             apply, wrap, lvl, exp_evt;
      logic [CNT_W-1:0] n_per;
      logic [1:0]       n_mode [CH];
      logic             n_pol  [CH];
      logic [CNT_W-1:0] n_c1   [CH];
      logic [CNT_W-1:0] n_c2   [CH];
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
            sb_q.delete();
         end else begin
            wrap  = pwm_en && (m_cnt == m_per);
            apply = wrap || !pwm_en;
            e.out = '0;
            for (int i = 0; i < CH; i++) begin
               if (m_mode[i] == 2'b00)      lvl = (m_cnt < m_c1[i]);
               else if (m_mode[i] == 2'b01) lvl = (m_cnt >= m_c1[i]);
               else if (m_mode[i] == 2'b10) lvl = (m_cnt >= m_c1[i]) && (m_cnt < m_c2[i]);
               else                         lvl = 1'b0;
               e.out[i] = pwm_en && (lvl ^ m_pol[i]);
               n_mode[i] = cfg_wr ? mode[2*i +: 2]              : s_mode[i];
               n_pol[i]  = cfg_wr ? pol[i]                      : s_pol[i];
               n_c1[i]   = cfg_wr ? compare1[i*CNT_W +: CNT_W]  : s_c1[i];
               n_c2[i]   = cfg_wr ? compare2[i*CNT_W +: CNT_W]  : s_c2[i];
            end
            n_per = cfg_wr ? period : s_per;
            m_cnt = apply ? '0 : m_cnt + 16'd1;
            if (cfg_wr) begin
               s_per = n_per;
               s_mode = n_mode; s_pol = n_pol; s_c1 = n_c1; s_c2 = n_c2;
            end
            if (apply) begin
               m_per = n_per;
               m_mode = n_mode; m_pol = n_pol; m_c1 = n_c1; m_c2 = n_c2;
               m_pend = 1'b0;
            end else if (cfg_wr) begin
               m_pend = 1'b1;
            end
            e.cnt  = m_cnt;
            e.pend = m_pend;
            sb_q.push_back(e);
            #1;
            got = sb_q.pop_front();
            exp_evt = pwm_en && (m_cnt == m_per);
            checks += 4;
            if (pwm_out !== got.out) begin
               errors++; $display("FAIL sb_pwm_out t=%0t got %b exp %b", $time, pwm_out, got.out);
            end
            if (count_val !== got.cnt) begin
               errors++; $display("FAIL sb_count t=%0t got %0d exp %0d", $time, count_val, got.cnt);
            end
            if (cfg_pending !== got.pend) begin
               errors++; $display("FAIL sb_pending t=%0t got %b exp %b", $time, cfg_pending, got.pend);
            end
            if (period_evt !== exp_evt) begin
               errors++; $display("FAIL sb_period_evt t=%0t got %b exp %b", $time, period_evt, exp_evt);
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog timeout got running exp finished");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_ch(input int i, input logic [1:0] md, input logic p,
                         input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
      mode[2*i +: 2]             = md;
      pol[i]                     = p;
      compare1[i*CNT_W +: CNT_W] = a;
      compare2[i*CNT_W +: CNT_W] = b;
   endtask

   task automatic write_cfg();
      cfg_wr = 1'b1;
      cyc();
      cfg_wr = 1'b0;
   endtask

   task automatic wait_count(input logic [CNT_W-1:0] v);
      int n = 0;
      while (count_val !== v && n < 50) begin
         cyc();
         n++;
      end
      checks++;
      if (count_val !== v) begin
         errors++; $display("FAIL wait_count got %0d exp %0d", count_val, v);
      end
   endtask

   task automatic test_reset();
      cyc(); cyc();
      checks += 4;
      if (pwm_out !== 4'b0000)   begin errors++; $display("FAIL reset_pwm_out got %b exp 0000", pwm_out); end
      if (count_val !== 16'd0)   begin errors++; $display("FAIL reset_count got %0d exp 0", count_val); end
      if (cfg_pending !== 1'b0)  begin errors++; $display("FAIL reset_pending got %b exp 0", cfg_pending); end
      if (period_evt !== 1'b0)   begin errors++; $display("FAIL reset_evt got %b exp 0", period_evt); end
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_basic();
      int hi [CH];
      int evts = 0;
      for (int i = 0; i < CH; i++) hi[i] = 0;
      period = 16'd9;
      set_ch(0, 2'b00, 1'b0, 16'd3, 16'd0);
      set_ch(1, 2'b01, 1'b0, 16'd7, 16'd0);
      set_ch(2, 2'b10, 1'b0, 16'd2, 16'd5);
      set_ch(3, 2'b10, 1'b0, 16'd5, 16'd2);
      write_cfg();
      checks++;
      if (cfg_pending !== 1'b0) begin errors++; $display("FAIL basic_pending_dis got %b exp 0", cfg_pending); end
      pwm_en = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         checks++;
         if (count_val !== 16'(k % 10)) begin
            errors++; $display("FAIL basic_count k=%0d got %0d exp %0d", k, count_val, k % 10);
         end
         for (int i = 0; i < CH; i++) hi[i] += int'(pwm_out[i]);
         evts += int'(period_evt);
         if (count_val == 16'd7) begin
            checks++;
            if (pwm_out[1] !== 1'b0) begin errors++; $display("FAIL basic_ch1_lag got %b exp 0", pwm_out[1]); end
         end
         if (count_val == 16'd8) begin
            checks++;
            if (pwm_out[1] !== 1'b1) begin errors++; $display("FAIL basic_ch1_on got %b exp 1", pwm_out[1]); end
         end
      end
      checks += 5;
      if (hi[0] != 6) begin errors++; $display("FAIL basic_ch0_high got %0d exp 6", hi[0]); end
      if (hi[1] != 6) begin errors++; $display("FAIL basic_ch1_high got %0d exp 6", hi[1]); end
      if (hi[2] != 6) begin errors++; $display("FAIL basic_ch2_high got %0d exp 6", hi[2]); end
      if (hi[3] != 0) begin errors++; $display("FAIL basic_ch3_high got %0d exp 0", hi[3]); end
      if (evts != 2)  begin errors++; $display("FAIL basic_evt_count got %0d exp 2", evts); end
   endtask

   task automatic test_update();
      int run = 0;
      int nruns = 0;
      logic seen_wrap = 1'b0;
      wait_count(16'd4);
      set_ch(0, 2'b00, 1'b0, 16'd8, 16'd0);
      write_cfg();
      checks++;
      if (cfg_pending !== 1'b1) begin errors++; $display("FAIL upd_pending_set got %b exp 1", cfg_pending); end
      for (int k = 0; k < 30; k++) begin
         cyc();
         if (count_val == 16'd0) seen_wrap = 1'b1;
         checks++;
         if (cfg_pending !== !seen_wrap) begin
            errors++; $display("FAIL upd_pending k=%0d got %b exp %b", k, cfg_pending, !seen_wrap);
         end
         if (pwm_out[0]) begin
            run++;
         end else if (run > 0) begin
            nruns++;
            checks++;
            if (run != 8) begin errors++; $display("FAIL upd_width got %0d exp 8", run); end
            run = 0;
         end
      end
      checks++;
      if (nruns != 2) begin errors++; $display("FAIL upd_runs got %0d exp 2", nruns); end
   endtask

   task automatic test_on_evt();
      int hi0 = 0;
      wait_count(16'd9);
      set_ch(0, 2'b00, 1'b0, 16'd3, 16'd0);
      write_cfg();
      for (int k = 0; k < 10; k++) begin
         checks++;
         if (cfg_pending !== 1'b0) begin errors++; $display("FAIL evt_pending k=%0d got %b exp 0", k, cfg_pending); end
         cyc();
         hi0 += int'(pwm_out[0]);
         if (count_val == 16'd4) begin
            checks++;
            if (pwm_out[0] !== 1'b0) begin errors++; $display("FAIL evt_new_c1 got %b exp 0", pwm_out[0]); end
         end
      end
      checks++;
      if (hi0 != 3) begin errors++; $display("FAIL evt_width got %0d exp 3", hi0); end
   endtask

   task automatic test_pol_off();
      set_ch(0, 2'b11, 1'b1, 16'd3, 16'd0);
      write_cfg();
      for (int k = 0; k < 12; k++) cyc();
      for (int k = 0; k < 5; k++) begin
         cyc();
         checks++;
         if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL pol_off_high k=%0d got %b exp 1", k, pwm_out[0]); end
      end
      pwm_en = 1'b0;
      cyc();
      checks += 2;
      if (pwm_out !== 4'b0000) begin errors++; $display("FAIL pol_off_dis got %b exp 0000", pwm_out); end
      if (count_val !== 16'd0) begin errors++; $display("FAIL pol_off_count got %0d exp 0", count_val); end
   endtask

   task automatic test_period0();
      period = 16'd0;
      set_ch(0, 2'b00, 1'b0, 16'd3, 16'd0);
      write_cfg();
      pwm_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         checks += 2;
         if (count_val !== 16'd0) begin errors++; $display("FAIL p0_count k=%0d got %0d exp 0", k, count_val); end
         if (period_evt !== 1'b1) begin errors++; $display("FAIL p0_evt k=%0d got %b exp 1", k, period_evt); end
      end
      checks++;
      if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL p0_ch0 got %b exp 1", pwm_out[0]); end
      set_ch(0, 2'b00, 1'b0, 16'd0, 16'd0);
      write_cfg();
      checks++;
      if (cfg_pending !== 1'b0) begin errors++; $display("FAIL p0_pending got %b exp 0", cfg_pending); end
      cyc();
      checks++;
      if (pwm_out[0] !== 1'b0) begin errors++; $display("FAIL p0_c1_zero got %b exp 0", pwm_out[0]); end
   endtask

   task automatic test_reset_mid();
      period = 16'd9;
      set_ch(0, 2'b00, 1'b0, 16'd3, 16'd0);
      set_ch(1, 2'b01, 1'b0, 16'd7, 16'd0);
      set_ch(2, 2'b11, 1'b1, 16'd0, 16'd0);
      set_ch(3, 2'b10, 1'b0, 16'd5, 16'd2);
      write_cfg();
      wait_count(16'd5);
      set_ch(1, 2'b00, 1'b0, 16'd9, 16'd0);
      write_cfg();
      checks += 2;
      if (cfg_pending !== 1'b1) begin errors++; $display("FAIL rmid_pre_pending got %b exp 1", cfg_pending); end
      if (pwm_out[2] !== 1'b1)  begin errors++; $display("FAIL rmid_pre_ch2 got %b exp 1", pwm_out[2]); end
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (count_val !== 16'd0)  begin errors++; $display("FAIL rmid_count got %0d exp 0", count_val); end
      if (pwm_out !== 4'b0000)  begin errors++; $display("FAIL rmid_pwm_out got %b exp 0000", pwm_out); end
      if (cfg_pending !== 1'b0) begin errors++; $display("FAIL rmid_pending got %b exp 0", cfg_pending); end
      cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         checks += 3;
         if (pwm_out !== 4'b0000) begin errors++; $display("FAIL rmid_cfg_lost k=%0d got %b exp 0000", k, pwm_out); end
         if (count_val !== 16'd0) begin errors++; $display("FAIL rmid_per0 k=%0d got %0d exp 0", k, count_val); end
         if (period_evt !== 1'b1) begin errors++; $display("FAIL rmid_evt k=%0d got %b exp 1", k, period_evt); end
      end
   endtask

   initial begin : main
      test_reset();
      test_basic();
      test_update();
      test_on_evt();
      test_pol_off();
      test_period0();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_gen_mc.md
# pwm_gen_mc

Multi-channel, parametrised PWM generator. Owns a shared free-running period counter and drives CH independent PWM outputs, each with its own alignment mode, compare pair and output polarity. Configuration is double-buffered so that new settings take effect only at a period boundary, which prevents glitched pulses. It sits between the register/SPI configuration front end and the top-level PWM pins, and replaces the single-channel generator that takes an external count value.

## Interface
- CH, 4: number of PWM channels (1..16)
- CNT_W, 16: counter, period and compare width (4..32)

- clk  in  1  peripheral clock
- rst_n  in  1  asynchronous active-low reset
- pwm_en  in  1  global enable; low holds counter at 0 and forces outputs low
- cfg_wr  in  1  one-cycle strobe; captures all config inputs below into staging
- period  in  CNT_W  counter terminal value; counter counts 0..period
- mode  in  2*CH  per channel [2i+1:2i]: 00 left, 01 right, 10 unaligned, 11 off
- pol  in  CH  per channel; 1 inverts the active output level
- compare1  in  CH*CNT_W  per channel, slice [i*CNT_W +: CNT_W]
- compare2  in  CH*CNT_W  per channel, used in unaligned mode only
- pwm_out  out  CH  registered PWM outputs
- count_val  out  CNT_W  current counter value
- period_evt  out  1  one-cycle pulse on the cycle in which count_val == active period while enabled
- cfg_pending  out  1  staging holds values not yet applied

## Operation
- Three register sets: staging (written by cfg_wr), active (used by compare logic), counter.
- Counter: while pwm_en=1, count_val increments by 1 per cycle and wraps to 0 on the cycle after count_val == active period. While pwm_en=0, count_val=0.
- Apply rule: active <= staging, and cfg_pending clears, on either of:
  - the wrap cycle (count_val == active period, pwm_en=1), or
  - any cycle with pwm_en=0.
- cfg_wr sets cfg_pending=1 unless the write is applied in the same cycle.
- cfg_wr coincident with an apply cycle: the incoming values pass straight to active, with no one-period delay.
- Raw per-channel level, from active registers and count_val:
  - left: count_val < c1
  - right: count_val >= c1
  - unaligned: c1 <= count_val < c2; c2 <= c1 gives a constant 0
  - off: 0
- pwm_out[i] <= pwm_en ? (raw ^ pol[i]) : 0. Off mode with pol=1 yields a constant 1.
- Compares are unsigned and full CNT_W width. c1=0 in left mode gives constant 0. c1 > period in left mode gives constant 1.
- period=0: count_val stays at 0, period_evt=1 every enabled cycle, and apply is possible every cycle.

## Timing
- Reset values: pwm_out=0, count_val=0, period_evt=0, cfg_pending=0. All staging and active registers reset to 0, so every channel starts in left mode with c1=0, i.e. output low.
- Latency: pwm_out in cycle t+1 reflects count_val and active config in cycle t.
- After pwm_en rises, count_val is 0 in the first enabled cycle and 1 in the next.
- Falling pwm_en: count_val=0 and pwm_out=0 from the next edge, and any pending config is applied at that edge.
- Reset asserted mid-period clears everything asynchronously. Staging contents are lost.
- cfg_wr is a level-sampled strobe. Holding it high rewrites staging every cycle, and the last value before the apply edge wins.

## Structure
- Shared package pwm_pkg holds:
  - mode localparams: PWM_LEFT=2'b00, PWM_RIGHT=2'b01, PWM_UNALIGNED=2'b10, PWM_OFF=2'b11
  - default CNT_W
- Sub-module pwm_chan: one channel's active registers, compare logic and output flop, instantiated CH times in a generate loop.
- The counter, apply logic and staging registers live in the top level.

## Test plan
- Reset then enable, CH=4, period=9, ch0 left c1=3, pol=0: pwm_out[0] high for 3 of every 10 cycles, count_val sequence 0..9, period_evt once every 10 cycles.
- ch1 right c1=7; ch2 unaligned c1=2 c2=5; ch3 unaligned c1=5 c2=2: ch1 high for count_val 7..9, ch2 high for 2..4, ch3 constant 0, all delayed one cycle from count_val.
- cfg_wr at count_val=4 changing ch0 c1 to 8: cfg_pending=1 until the wrap; current period keeps the 3-cycle pulse; next period gives an 8-cycle pulse; no intermediate pulse widths appear.
- cfg_wr exactly on the period_evt cycle: new values are used from count_val=0, and cfg_pending never asserts.
- pol[0]=1 with mode off, then pwm_en=0: pwm_out[0]=1 while enabled, 0 on the edge after pwm_en drops; count_val=0.
- period=0, and an rst_n pulse at count_val=6 with period=9: period_evt stays high every enabled cycle; the reset immediately zeroes count_val, pwm_out and the config.
